button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 93 +++++++++
 tb/tb_button_debounce.sv | 128 ++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, saturating debounce counter,
// registered press/release pulses and a press-driven toggle level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 state_q, state_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 toggle_q, toggle_d;
  logic                 differ_s;
  logic                 flip_s;

  // Next-state logic: the counter only advances while the synchronized level
  // disagrees with the debounced level, and the level flips on the final count.
  always_comb begin
    sync1_d   = btn_i;
    sync2_d   = sync1_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
    differ_s  = (sync2_q != state_q);
    flip_s    = differ_s && (cnt_q == CNT_LAST);

    if (!differ_s) begin
      cnt_d = CNT_ZERO;
    end else if (flip_s) begin
      cnt_d   = CNT_ZERO;
      state_d = ~state_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (flip_s) begin
      press_d   = ~state_q;
      release_d = state_q;
    end else begin
      press_d   = 1'b0;
      release_d = 1'b0;
    end

    if (press_d) begin
      toggle_d = ~toggle_q;
    end else begin
      toggle_d = toggle_q;
    end
  end

  // State registers; synchronous reset overrides every other update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= CNT_ZERO;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (DEBOUNCE_CYCLES = 4): stimulus queues
// expected press/release events; a negedge monitor pops and checks them.
module tb_button_debounce;

  typedef struct {
    bit kind;      // 0 = press, 1 = release
    int edge_no;
    bit state;
    bit toggle;
  } ev_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic btn_i = 1'b0;
  logic state_o, press_o, release_o, toggle_o;

  int  edge_n = 0;
  int  tests  = 0;
  int  fails  = 0;
  ev_t exp_q[$];

  button_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .btn_i     (btn_i),
    .state_o   (state_o),
    .press_o   (press_o),
    .release_o (release_o),
    .toggle_o  (toggle_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) edge_n = edge_n + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, req);
    end
  endtask

  // Wait for the negedge that follows edge k-1, so anything driven lands before edge k.
  task automatic goto_before(input int k);
    while (edge_n < k - 1) @(negedge clk_i);
  endtask

  task automatic expect_ev(input bit kind, input int e, input bit st, input bit tg);
    ev_t ev;
    ev.kind = kind; ev.edge_no = e; ev.state = st; ev.toggle = tg;
    exp_q.push_back(ev);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (press_o && release_o) check("press_and_release_together", 1, 0);
    if (press_o || release_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", edge_n, -1);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        check("pulse_kind",  int'(release_o), int'(ev.kind));
        check("pulse_edge",  edge_n,          ev.edge_no);
        check("pulse_state", int'(state_o),   int'(ev.state));
        check("pulse_toggle", int'(toggle_o), int'(ev.toggle));
      end
    end
  end

  initial begin
    // Reset for edges 1..3
    goto_before(4);
    check("rst_state",   int'(state_o),   0);
    check("rst_press",   int'(press_o),   0);
    check("rst_release", int'(release_o), 0);
    check("rst_toggle",  int'(toggle_o),  0);
    rst_i = 1'b0;

    // Clean press: high before edge 10 -> press at 15
    expect_ev(1'b0, 15, 1'b1, 1'b1);
    goto_before(10); btn_i = 1'b1;
    // Release: low before edge 20 -> release at 25, toggle stays 1
    expect_ev(1'b1, 25, 1'b0, 1'b1);
    goto_before(20); btn_i = 1'b0;

    // Glitch: high for 3 cycles only -> no event
    goto_before(30); btn_i = 1'b1;
    goto_before(33); btn_i = 1'b0;
    goto_before(40);
    check("glitch_state",  int'(state_o),  0);
    check("glitch_toggle", int'(toggle_o), 1);

    // Bounce 1,0,1,1,... from edge 40 -> single press at 47, toggle back to 0
    btn_i = 1'b1;
    expect_ev(1'b0, 47, 1'b1, 1'b0);
    goto_before(41); btn_i = 1'b0;
    goto_before(42); btn_i = 1'b1;
    goto_before(50);
    check("bounce_state", int'(state_o), 1);

    // Release -> 60
    expect_ev(1'b1, 60, 1'b0, 1'b0);
    goto_before(55); btn_i = 1'b0;

    // Reset mid-count: high before 70, cnt=2 after edge 73, reset at edge 74
    goto_before(70); btn_i = 1'b1;
    goto_before(74); rst_i = 1'b1;
    goto_before(75);
    check("midrst_state",   int'(state_o),   0);
    check("midrst_press",   int'(press_o),   0);
    check("midrst_release", int'(release_o), 0);
    check("midrst_toggle",  int'(toggle_o),  0);
    rst_i = 1'b0;
    // First non-reset edge 75 -> press at 80
    expect_ev(1'b0, 80, 1'b1, 1'b1);

    goto_before(90);
    check("final_state",  int'(state_o),  1);
    check("final_toggle", int'(toggle_o), 1);
    check("events_outstanding", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
